// File: rtl/onesecond_mux_timer.sv
// onesecond_mux_timer
//   Multi-digit seconds timer driving a multiplexed 7-segment display.
//   Everything runs on CLK1; there are no derived clocks. A prescaler emits a
//   one-cycle tick every TICKS cycles. Each tick steps a DIGITS-wide BCD (or hex)
//   up/down counter. The counter feeds a registered segment decoder and an anode
//   scanner.
//
// Ports
//   CLK1   in   system clock
//   arst   in   synchronous active-high reset (name kept for board compatibility)
//   run    in   1 = prescaler advances, 0 = pause
//   up     in   count direction, sampled only on the tick edge
//   clear  in   synchronous clear of prescaler and count (display scan keeps going)
//   seg    out  active-low segments, seg[0]=a .. seg[6]=g
//   dp     out  active-low decimal point, lit on digit 0 while paused
//   an     out  active-low one-hot anode select, an[0] = least significant digit
//   Led    out  current value of digit 0
//   tick   out  one-cycle pulse on each count step
//   wrap   out  one-cycle pulse on roll-over (up) or roll-under (down)
module onesecond_mux_timer #(
    parameter int CRYSTAL     = 50,
    parameter int NUM_SEC     = 1,
    parameter int TICKS       = CRYSTAL * 1_000_000 * NUM_SEC,
    parameter int DIGITS      = 4,
    parameter int HEX_MODE    = 0,
    parameter int REFRESH_DIV = 50_000
) (
    input  logic              CLK1,
    input  logic              arst,
    input  logic              run,
    input  logic              up,
    input  logic              clear,
    output logic [0:6]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] an,
    output logic [3:0]        Led,
    output logic              tick,
    output logic              wrap
);

    localparam int PW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [3:0] MAX = (HEX_MODE != 0) ? 4'd15 : 4'd9;

    logic [PW-1:0]         pcnt_q;
    logic [DIGITS*4-1:0]   count_q, count_d;
    logic                  tick_q, wrap_q, wrap_d;
    logic                  carry;
    logic [3:0]            digit;
    logic [RW-1:0]         refCnt_q;
    logic [SW-1:0]         sel_q;
    logic [3:0]            scanDigit;
    logic [0:6]            seg_q;
    logic                  dp_q;
    logic [DIGITS-1:0]     an_q;

    // Active-low glyphs in a..g order. Letters only exist in hex mode; a
    // decimal-mode value above 9 cannot occur, but blanks rather than lies.
    function automatic logic [0:6] glyph(input logic [3:0] v);
        logic [0:6] g;
        case (v)
            4'h0:    g = 7'b0000001;
            4'h1:    g = 7'b1001111;
            4'h2:    g = 7'b0010010;
            4'h3:    g = 7'b0000110;
            4'h4:    g = 7'b1001100;
            4'h5:    g = 7'b0100100;
            4'h6:    g = 7'b0100000;
            4'h7:    g = 7'b0001111;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0000100;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b1100000;
            4'hC:    g = 7'b0110001;
            4'hD:    g = 7'b1000010;
            4'hE:    g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        if (HEX_MODE == 0 && v > 4'd9) begin
            g = 7'b1111111;
        end
        return g;
    endfunction

    // Ripple carry/borrow through the digits. The carry left over after the
    // last digit means every digit rolled, which is exactly the wrap condition.
    always_comb begin
        count_d = count_q;
        carry   = 1'b1;
        digit   = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            digit = count_q[i*4 +: 4];
            if (carry) begin
                if (up) begin
                    if (digit == MAX) begin
                        count_d[i*4 +: 4] = 4'd0;
                    end else begin
                        count_d[i*4 +: 4] = digit + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (digit == 4'd0) begin
                        count_d[i*4 +: 4] = MAX;
                    end else begin
                        count_d[i*4 +: 4] = digit - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
        wrap_d = carry;
    end

    // Prescaler and counter. Pausing freezes pcnt so a resumed interval only
    // runs for its remaining cycles.
    always_ff @(posedge CLK1) begin
        if (arst || clear) begin
            pcnt_q  <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (run && pcnt_q == PW'(TICKS - 1)) begin
            pcnt_q  <= '0;
            count_q <= count_d;
            tick_q  <= 1'b1;
            wrap_q  <= wrap_d;
        end else begin
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            if (run) begin
                pcnt_q <= pcnt_q + PW'(1);
            end
        end
    end

    always_comb begin
        scanDigit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel_q == SW'(i)) begin
                scanDigit = count_q[i*4 +: 4];
            end
        end
    end

    // Display scan. an, seg and dp are all registered from the same sel_q so
    // the anode and glyph always change on the same edge.
    always_ff @(posedge CLK1) begin
        if (arst) begin
            refCnt_q <= '0;
            sel_q    <= '0;
            an_q     <= ~DIGITS'(1);
            seg_q    <= 7'b0000001;
            dp_q     <= 1'b1;
        end else begin
            if (refCnt_q == RW'(REFRESH_DIV - 1)) begin
                refCnt_q <= '0;
                sel_q    <= (sel_q == SW'(DIGITS - 1)) ? '0 : sel_q + SW'(1);
            end else begin
                refCnt_q <= refCnt_q + RW'(1);
            end
            an_q  <= ~(DIGITS'(1) << sel_q);
            seg_q <= glyph(scanDigit);
            dp_q  <= !(sel_q == '0 && !run);
        end
    end

    assign seg  = seg_q;
    assign dp   = dp_q;
    assign an   = an_q;
    assign Led  = count_q[3:0];
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_onesecond_mux_timer.sv
// tb_onesecond_mux_timer
//   Directed bench for onesecond_mux_timer with TICKS=4, DIGITS=2,
//   REFRESH_DIV=2. A decimal instance and a hex instance share clock and
//   inputs so that both counting modes are checked against hand-computed
//   values. Inputs change and outputs are sampled 1 time unit after each
//   rising edge.
module tb_onesecond_mux_timer;

    logic       CLK1 = 1'b0;
    logic       arst, run, up, clear;
    logic [0:6] segD, segH;
    logic       dpD, dpH;
    logic [1:0] anD, anH;
    logic [3:0] LedD, LedH;
    logic       tickD, tickH, wrapD, wrapH;

    int checks = 0;
    int errors = 0;

    always #5 CLK1 = ~CLK1;

    onesecond_mux_timer #(.TICKS(4), .DIGITS(2), .HEX_MODE(0), .REFRESH_DIV(2)) dutDec (
        .CLK1(CLK1), .arst(arst), .run(run), .up(up), .clear(clear),
        .seg(segD), .dp(dpD), .an(anD), .Led(LedD), .tick(tickD), .wrap(wrapD)
    );

    onesecond_mux_timer #(.TICKS(4), .DIGITS(2), .HEX_MODE(1), .REFRESH_DIV(2)) dutHex (
        .CLK1(CLK1), .arst(arst), .run(run), .up(up), .clear(clear),
        .seg(segH), .dp(dpH), .an(anH), .Led(LedH), .tick(tickH), .wrap(wrapH)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK1);
            #1;
        end
    endtask

    task automatic doReset();
        arst = 1'b1; clear = 1'b0; run = 1'b0; up = 1'b1;
        cyc(1);
        arst = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1; run = 1'b0; up = 1'b1; clear = 1'b0;
        cyc(2);
        checks++; if (tickD !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick got %b want 0", tickD); end
        checks++; if (wrapD !== 1'b0) begin errors++; $display("[TB] FAIL reset_wrap got %b want 0", wrapD); end
        checks++; if (LedD !== 4'd0) begin errors++; $display("[TB] FAIL reset_led got %h want 0", LedD); end
        checks++; if (anD !== 2'b10) begin errors++; $display("[TB] FAIL reset_an got %b want 10", anD); end
        checks++; if (segD !== 7'b0000001) begin errors++; $display("[TB] FAIL reset_seg got %b want 0000001", segD); end
        checks++; if (dpD !== 1'b1) begin errors++; $display("[TB] FAIL reset_dp got %b want 1", dpD); end
        checks++; if (LedH !== 4'd0) begin errors++; $display("[TB] FAIL reset_led_hex got %h want 0", LedH); end
    endtask

    // Ten steps from reset: decimal reads 1..9 then 0 (count 10), hex reads 1..A.
    task automatic test_count();
        arst = 1'b0; run = 1'b1; up = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc(3);
            checks++; if (tickD !== 1'b0) begin errors++; $display("[TB] FAIL count_notick k=%0d got %b want 0", k, tickD); end
            cyc(1);
            checks++; if (tickD !== 1'b1) begin errors++; $display("[TB] FAIL count_tick k=%0d got %b want 1", k, tickD); end
            checks++; if (wrapD !== 1'b0) begin errors++; $display("[TB] FAIL count_wrap k=%0d got %b want 0", k, wrapD); end
            checks++; if (LedD !== 4'(k % 10)) begin errors++; $display("[TB] FAIL count_led k=%0d got %h want %h", k, LedD, k % 10); end
            checks++; if (LedH !== 4'(k)) begin errors++; $display("[TB] FAIL count_led_hex k=%0d got %h want %h", k, LedH, k); end
        end
    endtask

    // Continues from count 10: up to 99, roll to 00, then count down.
    task automatic test_wrap();
        repeat (89) cyc(4);
        checks++; if (LedD !== 4'd9) begin errors++; $display("[TB] FAIL wrap_at99 got %h want 9", LedD); end
        checks++; if (wrapD !== 1'b0) begin errors++; $display("[TB] FAIL wrap_at99_wrap got %b want 0", wrapD); end
        cyc(4);
        checks++; if (tickD !== 1'b1) begin errors++; $display("[TB] FAIL wrapup_tick got %b want 1", tickD); end
        checks++; if (wrapD !== 1'b1) begin errors++; $display("[TB] FAIL wrapup_wrap got %b want 1", wrapD); end
        checks++; if (LedD !== 4'd0) begin errors++; $display("[TB] FAIL wrapup_led got %h want 0", LedD); end
        checks++; if (wrapH !== 1'b0) begin errors++; $display("[TB] FAIL wrapup_hex_wrap got %b want 0", wrapH); end
        checks++; if (LedH !== 4'd4) begin errors++; $display("[TB] FAIL wrapup_hex_led got %h want 4", LedH); end
        cyc(1);
        checks++; if (wrapD !== 1'b0) begin errors++; $display("[TB] FAIL wrap_pulse_len got %b want 0", wrapD); end
        up = 1'b0;
        cyc(3);
        checks++; if (tickD !== 1'b1) begin errors++; $display("[TB] FAIL wrapdn_tick got %b want 1", tickD); end
        checks++; if (wrapD !== 1'b1) begin errors++; $display("[TB] FAIL wrapdn_wrap got %b want 1", wrapD); end
        checks++; if (LedD !== 4'd9) begin errors++; $display("[TB] FAIL wrapdn_led got %h want 9", LedD); end
        checks++; if (LedH !== 4'd3) begin errors++; $display("[TB] FAIL wrapdn_hex_led got %h want 3", LedH); end
        up = 1'b1;
        cyc(2);
        checks++; if (LedD !== 4'd9) begin errors++; $display("[TB] FAIL dir_between_ticks got %h want 9", LedD); end
        up = 1'b0;
        cyc(2);
        checks++; if (tickD !== 1'b1) begin errors++; $display("[TB] FAIL dir_tick got %b want 1", tickD); end
        checks++; if (LedD !== 4'd8) begin errors++; $display("[TB] FAIL dir_led got %h want 8", LedD); end
        checks++; if (wrapD !== 1'b0) begin errors++; $display("[TB] FAIL dir_wrap got %b want 0", wrapD); end
        checks++; if (LedH !== 4'd2) begin errors++; $display("[TB] FAIL dir_hex_led got %h want 2", LedH); end
    endtask

    // Hex: 0F -> 10 at step 16, FF -> 00 with wrap at step 256.
    task automatic test_hex();
        doReset();
        run = 1'b1; up = 1'b1;
        for (int t = 1; t <= 256; t++) begin
            cyc(4);
            if (t == 15 || t == 255) begin
                checks++; if (LedH !== 4'hF) begin errors++; $display("[TB] FAIL hex_f t=%0d got %h want f", t, LedH); end
            end
            if (t == 16) begin
                checks++; if (LedH !== 4'h0) begin errors++; $display("[TB] FAIL hex_10_led got %h want 0", LedH); end
                checks++; if (wrapH !== 1'b0) begin errors++; $display("[TB] FAIL hex_10_wrap got %b want 0", wrapH); end
                checks++; if (LedD !== 4'd6) begin errors++; $display("[TB] FAIL hex_10_dec got %h want 6", LedD); end
            end
            if (t == 256) begin
                checks++; if (LedH !== 4'h0) begin errors++; $display("[TB] FAIL hex_ff_led got %h want 0", LedH); end
                checks++; if (wrapH !== 1'b1) begin errors++; $display("[TB] FAIL hex_ff_wrap got %b want 1", wrapH); end
                checks++; if (tickH !== 1'b1) begin errors++; $display("[TB] FAIL hex_ff_tick got %b want 1", tickH); end
                checks++; if (wrapD !== 1'b0) begin errors++; $display("[TB] FAIL hex_ff_dec_wrap got %b want 0", wrapD); end
                checks++; if (LedD !== 4'd6) begin errors++; $display("[TB] FAIL hex_ff_dec got %h want 6", LedD); end
            end
        end
    endtask

    // Pause after two prescaler cycles for ten cycles; resume needs two more.
    task automatic test_pause();
        int dpLow;
        dpLow = 0;
        doReset();
        run = 1'b1; up = 1'b1;
        cyc(2);
        run = 1'b0;
        cyc(1);
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            checks++; if (tickD !== 1'b0) begin errors++; $display("[TB] FAIL pause_tick i=%0d got %b want 0", i, tickD); end
            if (dpD === 1'b0) begin
                dpLow++;
                checks++; if (anD !== 2'b10) begin errors++; $display("[TB] FAIL pause_dp_digit got an=%b want 10", anD); end
            end
        end
        checks++; if (dpLow !== 4) begin errors++; $display("[TB] FAIL pause_dp_count got %0d want 4", dpLow); end
        checks++; if (LedD !== 4'd0) begin errors++; $display("[TB] FAIL pause_led got %h want 0", LedD); end
        cyc(1);
        run = 1'b1;
        cyc(1);
        checks++; if (tickD !== 1'b0) begin errors++; $display("[TB] FAIL resume_early got %b want 0", tickD); end
        cyc(1);
        checks++; if (tickD !== 1'b1) begin errors++; $display("[TB] FAIL resume_tick got %b want 1", tickD); end
        checks++; if (LedD !== 4'd1) begin errors++; $display("[TB] FAIL resume_led got %h want 1", LedD); end
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            checks++; if (dpD !== 1'b1) begin errors++; $display("[TB] FAIL run_dp i=%0d got %b want 1", i, dpD); end
        end
    endtask

    // Clear on the tick edge wins; reset mid-count restores every reset value.
    task automatic test_clear();
        doReset();
        run = 1'b1; up = 1'b1;
        repeat (5) cyc(4);
        checks++; if (LedD !== 4'd5) begin errors++; $display("[TB] FAIL clear_pre got %h want 5", LedD); end
        cyc(3);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        checks++; if (tickD !== 1'b0) begin errors++; $display("[TB] FAIL clear_tick got %b want 0", tickD); end
        checks++; if (wrapD !== 1'b0) begin errors++; $display("[TB] FAIL clear_wrap got %b want 0", wrapD); end
        checks++; if (LedD !== 4'd0) begin errors++; $display("[TB] FAIL clear_led got %h want 0", LedD); end
        cyc(3);
        checks++; if (tickD !== 1'b0) begin errors++; $display("[TB] FAIL clear_after_early got %b want 0", tickD); end
        cyc(1);
        checks++; if (tickD !== 1'b1) begin errors++; $display("[TB] FAIL clear_after_tick got %b want 1", tickD); end
        checks++; if (LedD !== 4'd1) begin errors++; $display("[TB] FAIL clear_after_led got %h want 1", LedD); end
        cyc(2);
        arst = 1'b1;
        cyc(1);
        arst = 1'b0;
        checks++; if (LedD !== 4'd0) begin errors++; $display("[TB] FAIL arst_led got %h want 0", LedD); end
        checks++; if (tickD !== 1'b0) begin errors++; $display("[TB] FAIL arst_tick got %b want 0", tickD); end
        checks++; if (anD !== 2'b10) begin errors++; $display("[TB] FAIL arst_an got %b want 10", anD); end
        checks++; if (segD !== 7'b0000001) begin errors++; $display("[TB] FAIL arst_seg got %b want 0000001", segD); end
        checks++; if (dpD !== 1'b1) begin errors++; $display("[TB] FAIL arst_dp got %b want 1", dpD); end
        cyc(3);
        checks++; if (tickD !== 1'b0) begin errors++; $display("[TB] FAIL arst_after_early got %b want 0", tickD); end
        cyc(1);
        checks++; if (tickD !== 1'b1) begin errors++; $display("[TB] FAIL arst_after_tick got %b want 1", tickD); end
    endtask

    // Count 37 (hex 0x25) and watch the scan.
    task automatic test_scan();
        logic [1:0] anHist [8];
        doReset();
        run = 1'b1; up = 1'b1;
        repeat (37) cyc(4);
        run = 1'b0;
        checks++; if (LedD !== 4'd7) begin errors++; $display("[TB] FAIL scan_led got %h want 7", LedD); end
        cyc(2);
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            anHist[i] = anD;
            checks++;
            if (anD === 2'b10) begin
                if (segD !== 7'b0001111) begin errors++; $display("[TB] FAIL scan_dig0 got %b want 0001111", segD); end
            end else if (anD === 2'b01) begin
                if (segD !== 7'b0000110) begin errors++; $display("[TB] FAIL scan_dig1 got %b want 0000110", segD); end
            end else begin
                errors++; $display("[TB] FAIL scan_an got %b want 10 or 01", anD);
            end
            checks++;
            if (anH === 2'b10) begin
                if (segH !== 7'b0100100) begin errors++; $display("[TB] FAIL scan_hex_dig0 got %b want 0100100", segH); end
            end else if (anH === 2'b01) begin
                if (segH !== 7'b0010010) begin errors++; $display("[TB] FAIL scan_hex_dig1 got %b want 0010010", segH); end
            end else begin
                errors++; $display("[TB] FAIL scan_hex_an got %b want 10 or 01", anH);
            end
        end
        for (int i = 2; i < 8; i++) begin
            checks++;
            if (anHist[i] === anHist[i-2]) begin
                errors++; $display("[TB] FAIL scan_period i=%0d got %b want not %b", i, anHist[i], anHist[i-2]);
            end
        end
    endtask

    initial begin
        arst = 1'b1; run = 1'b0; up = 1'b1; clear = 1'b0;
        test_reset();
        test_count();
        test_wrap();
        test_hex();
        test_pause();
        test_clear();
        test_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
